vram_port_arbiter: RTL and testbench
====================================

// Module: vram_port_arbiter
// PURPOSE
//  Sole owner of the single-port video RAM. Shares it between CPU WVM writes and VGA scanout reads.
//  CPU writes go through a small write buffer; VGA reads have strict priority and a fixed latency.
//  Also sequences a full-screen clear with one colour, for boot and for program-requested screen wipes.
//  Sits between the CPU execute stage / VGA timing generator and the VRAM macro.
// PARAMETERS
//  ADDR_WIDTH   16    VRAM word address width (CPU and VGA address space)
//  COLOR_WIDTH  3     pixel word width ({R,G,B})
//  FIFO_DEPTH   4     write-buffer entries; power of two, >=2
//  CLEAR_WORDS  1024  words written by a clear: addresses 0..CLEAR_WORDS-1
// PORTS
//  Clock            in   1            system clock, all logic on rising edge
//  Reset            in   1            synchronous, active-high
//  iCpuWriteEnable  in   1            CPU write request (WVM)
//  iCpuAddress      in   ADDR_WIDTH   CPU write address
//  iCpuColor        in   COLOR_WIDTH  CPU write data
//  oCpuStall        out  1            1: write not accepted this cycle; CPU holds the request
//  iClearReq        in   1            start clear (single-cycle pulse or level)
//  iClearColor      in   COLOR_WIDTH  fill colour, sampled when the clear is accepted
//  oClearBusy       out  1            clear in progress
//  iVgaReadReq      in   1            VGA pixel read request
//  iVgaAddress      in   ADDR_WIDTH   VGA read address
//  oVgaData         out  COLOR_WIDTH  read data, registered
//  oVgaDataValid    out  1            oVgaData valid this cycle
//  oRamAddress      out  ADDR_WIDTH   VRAM address (combinational mux)
//  oRamWriteData    out  COLOR_WIDTH  VRAM write data (combinational mux)
//  oRamWriteEnable  out  1            VRAM write strobe
//  iRamReadData     in   COLOR_WIDTH  VRAM read data, valid the cycle after the address
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, clear counter 0.
//   Outputs: oCpuStall=0, oClearBusy=0, oVgaData=0, oVgaDataValid=0, oRamWriteEnable=0.
//  Port priority, evaluated each cycle:
//   1. VGA read.
//   2. Clear write, in CLEAR.
//   3. FIFO head write, in IDLE.
//  VGA read:
//   - Request in cycle t: oRamAddress=iVgaAddress and oRamWriteEnable=0 in cycle t.
//   - oVgaData=iRamReadData registered at end of t+1, so valid in t+2 with oVgaDataValid=1.
//   - Fixed latency 2, in every state; back-to-back requests give back-to-back data.
//  Read/write ordering: no forwarding. A read of an address with a pending write returns the current RAM contents.
//  CPU write accept: iCpuWriteEnable && !oCpuStall; entry {address, colour} pushed at end of cycle.
//  oCpuStall is combinational: (count==FIFO_DEPTH) || (state==CLEAR) || clear accepted this cycle.
//   - When full, push and pop in the same cycle is not allowed: stall is set by count alone.
//  Drain: in IDLE with no VGA request and count>0, the head is written and popped that cycle.
//   - A write accepted at t into an empty FIFO reaches RAM at t+1 at the earliest.
//  FIFO pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
//   - count never overflows or underflows.
//  States:
//   IDLE -> CLEAR on iClearReq. Same edge: FIFO flushed (pending writes discarded), colour latched, counter=0.
//   CLEAR -> CLEAR: each cycle without a VGA request writes latched colour to address=counter, then counter++.
//    - A VGA request pauses the counter.
//   CLEAR -> IDLE on the edge that writes address CLEAR_WORDS-1.
//  oClearBusy: registered, 1 exactly while state==CLEAR.
//  iClearReq while CLEAR is ignored; there is no restart.
//   - A clear request and a CPU write in the same IDLE cycle: the clear wins and the write is stalled.
//  Reset mid-clear or with a non-empty FIFO: everything returns to reset values next edge.
//   - VRAM is left partially written; this is allowed.
//  oRamWriteEnable is never 1 in a cycle with iVgaReadReq=1.
// TESTING
//  1. Reset, then VGA read at 0x0010 while RAM holds 3'b010 -> oVgaData=3'b010 with valid exactly 2 cycles later.
//  2. CPU write 0x0005/3'b100 with no VGA traffic -> RAM write at 0x0005 next cycle; FIFO empty after.
//  3. VGA reads every cycle while CPU writes 5 words -> 4 accepted, oCpuStall=1 on the 5th.
//     Drop VGA -> 4 writes in order, then the 5th is accepted.
//  4. 3 writes buffered, then iClearReq with 3'b001 -> writes discarded, oClearBusy for 1024 cycles.
//     Result: addresses 0..1023 = 3'b001, and no write above 1023.
//  5. Clear with a VGA read every other cycle -> reads keep latency 2; clear takes 2048 cycles; last write at address 1023.
//  6. Reset asserted at clear address 0x0200 -> next cycle oClearBusy=0, oRamWriteEnable=0, oCpuStall=0.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// -----------------------------------------------------------------------------
// vram_port_arbiter
//
// Sole owner of the single-port video RAM. Three clients share the port:
//   - VGA scanout reads: strict priority, fixed two-cycle read latency.
//   - Full-screen clear: writes one latched colour to addresses
//     0..CLEAR_WORDS-1, pausing whenever the VGA reads.
//   - CPU writes: buffered in a small FIFO, drained in IDLE when the port is
//     otherwise free.
//
// Ports
//   Clock, Reset          rising-edge clock, synchronous active-high reset
//   iCpuWriteEnable       CPU write request; held by the CPU while oCpuStall=1
//   iCpuAddress/iCpuColor CPU write address / data
//   oCpuStall             write not accepted this cycle (combinational)
//   iClearReq             start a clear (pulse or level), ignored while clearing
//   iClearColor           fill colour, latched when the clear is accepted
//   oClearBusy            clear in progress (registered)
//   iVgaReadReq           VGA pixel read request
//   iVgaAddress           VGA read address
//   oVgaData              read data, registered
//   oVgaDataValid         oVgaData valid, two cycles after the request
//   oRamAddress           VRAM address (combinational mux)
//   oRamWriteData         VRAM write data (combinational mux)
//   oRamWriteEnable       VRAM write strobe
//   iRamReadData          VRAM read data, valid the cycle after the address
//
// States
//   state    | meaning
//   ST_IDLE  | CPU write buffer drains when the VGA is not reading
//   ST_CLEAR | clear sequencer owns all write slots, CPU is stalled
// -----------------------------------------------------------------------------
module vram_port_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int COLOR_WIDTH = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int CLEAR_WORDS = 1024
) (
    input  logic                   Clock,
    input  logic                   Reset,

    input  logic                   iCpuWriteEnable,
    input  logic [ADDR_WIDTH-1:0]  iCpuAddress,
    input  logic [COLOR_WIDTH-1:0] iCpuColor,
    output logic                   oCpuStall,

    input  logic                   iClearReq,
    input  logic [COLOR_WIDTH-1:0] iClearColor,
    output logic                   oClearBusy,

    input  logic                   iVgaReadReq,
    input  logic [ADDR_WIDTH-1:0]  iVgaAddress,
    output logic [COLOR_WIDTH-1:0] oVgaData,
    output logic                   oVgaDataValid,

    output logic [ADDR_WIDTH-1:0]  oRamAddress,
    output logic [COLOR_WIDTH-1:0] oRamWriteData,
    output logic                   oRamWriteEnable,
    input  logic [COLOR_WIDTH-1:0] iRamReadData
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLR_W = $clog2(CLEAR_WORDS);

    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CLR_W-1:0] CLEAR_LAST    = CLR_W'(CLEAR_WORDS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q,       state_d;

    logic [PTR_W-1:0]       wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,      rd_ptr_d;
    logic [CNT_W-1:0]       count_q,       count_d;
    logic [ADDR_WIDTH-1:0]  fifo_addr_q    [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_addr_d    [FIFO_DEPTH];
    logic [COLOR_WIDTH-1:0] fifo_color_q   [FIFO_DEPTH];
    logic [COLOR_WIDTH-1:0] fifo_color_d   [FIFO_DEPTH];

    logic [CLR_W-1:0]       clear_cnt_q,   clear_cnt_d;
    logic [COLOR_WIDTH-1:0] clear_color_q, clear_color_d;

    logic                   vga_pend_q,    vga_pend_d;
    logic                   vga_valid_q,   vga_valid_d;
    logic [COLOR_WIDTH-1:0] vga_data_q,    vga_data_d;

    // ------------------------------------------------------------------
    // Port arbitration decisions
    // ------------------------------------------------------------------
    logic fifo_full;
    logic fifo_empty;
    logic clear_accept;
    logic clear_write;
    logic cpu_push;
    logic fifo_pop;

    always_comb begin
        fifo_full    = (count_q == FIFO_FULL_CNT);
        fifo_empty   = (count_q == '0);
        clear_accept = (state_q == ST_IDLE) && iClearReq;

        // Full stalls on count alone: a same-cycle pop never frees the slot.
        oCpuStall    = fifo_full || (state_q == ST_CLEAR) || clear_accept;
        cpu_push     = iCpuWriteEnable && !oCpuStall;

        clear_write  = (state_q == ST_CLEAR) && !iVgaReadReq;

        // The buffered writes are being discarded in the accept cycle, so the
        // head is not sent to RAM either.
        fifo_pop     = (state_q == ST_IDLE) && !iVgaReadReq && !fifo_empty
                       && !clear_accept;
    end

    // ------------------------------------------------------------------
    // RAM port mux: VGA read > clear write > FIFO head write
    // ------------------------------------------------------------------
    always_comb begin
        oRamAddress     = iVgaAddress;
        oRamWriteData   = '0;
        oRamWriteEnable = 1'b0;
        if (iVgaReadReq) begin
            oRamAddress     = iVgaAddress;
        end else if (clear_write) begin
            oRamAddress     = ADDR_WIDTH'(clear_cnt_q);
            oRamWriteData   = clear_color_q;
            oRamWriteEnable = 1'b1;
        end else if (fifo_pop) begin
            oRamAddress     = fifo_addr_q[rd_ptr_q];
            oRamWriteData   = fifo_color_q[rd_ptr_q];
            oRamWriteEnable = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write buffer
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        fifo_addr_d  = fifo_addr_q;
        fifo_color_d = fifo_color_q;

        if (cpu_push) begin
            fifo_addr_d[wr_ptr_q]  = iCpuAddress;
            fifo_color_d[wr_ptr_q] = iCpuColor;
            wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({cpu_push, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Starting a clear throws away everything still buffered.
        if (clear_accept) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // ------------------------------------------------------------------
    // Clear sequencer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        clear_cnt_d   = clear_cnt_q;
        clear_color_d = clear_color_q;

        unique case (state_q)
            ST_IDLE: begin
                if (iClearReq) begin
                    state_d       = ST_CLEAR;
                    clear_cnt_d   = '0;
                    clear_color_d = iClearColor;
                end
            end
            ST_CLEAR: begin
                if (clear_write) begin
                    if (clear_cnt_q == CLEAR_LAST) begin
                        state_d     = ST_IDLE;
                        clear_cnt_d = '0;
                    end else begin
                        clear_cnt_d = clear_cnt_q + CLR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign oClearBusy = (state_q == ST_CLEAR);

    // ------------------------------------------------------------------
    // VGA read return: address in t, RAM data in t+1, registered for t+2
    // ------------------------------------------------------------------
    always_comb begin
        vga_pend_d  = iVgaReadReq;
        vga_valid_d = vga_pend_q;
        vga_data_d  = vga_pend_q ? iRamReadData : vga_data_q;
    end

    assign oVgaData      = vga_data_q;
    assign oVgaDataValid = vga_valid_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i]  <= '0;
                fifo_color_q[i] <= '0;
            end
            clear_cnt_q   <= '0;
            clear_color_q <= '0;
            vga_pend_q    <= 1'b0;
            vga_valid_q   <= 1'b0;
            vga_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fifo_addr_q   <= fifo_addr_d;
            fifo_color_q  <= fifo_color_d;
            clear_cnt_q   <= clear_cnt_d;
            clear_color_q <= clear_color_d;
            vga_pend_q    <= vga_pend_d;
            vga_valid_q   <= vga_valid_d;
            vga_data_q    <= vga_data_d;
        end
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_port_arbiter
//
// Directed bench: a table of single-cycle vectors for IDLE-state arbitration,
// then hand-written sequences for clear, clear with interleaved VGA reads and
// reset mid-clear. A behavioural single-port RAM (read data one cycle after
// the address, read-before-write) sits on the VRAM port.
// -----------------------------------------------------------------------------
module tb_vram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [2:0]  cpu_color;
    logic        cpu_stall;
    logic        clr_req;
    logic [2:0]  clr_color;
    logic        clr_busy;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic [2:0]  vga_data;
    logic        vga_valid;
    logic [15:0] ram_addr;
    logic [2:0]  ram_wdata;
    logic        ram_we;
    logic [2:0]  ram_rdata;

    always #5 clk = ~clk;

    vram_port_arbiter #(
        .ADDR_WIDTH (16),
        .COLOR_WIDTH(3),
        .FIFO_DEPTH (4),
        .CLEAR_WORDS(1024)
    ) dut (
        .Clock          (clk),
        .Reset          (rst),
        .iCpuWriteEnable(cpu_we),
        .iCpuAddress    (cpu_addr),
        .iCpuColor      (cpu_color),
        .oCpuStall      (cpu_stall),
        .iClearReq      (clr_req),
        .iClearColor    (clr_color),
        .oClearBusy     (clr_busy),
        .iVgaReadReq    (vga_req),
        .iVgaAddress    (vga_addr),
        .oVgaData       (vga_data),
        .oVgaDataValid  (vga_valid),
        .oRamAddress    (ram_addr),
        .oRamWriteData  (ram_wdata),
        .oRamWriteEnable(ram_we),
        .iRamReadData   (ram_rdata)
    );

    // RAM model. Initial contents: mem[a] = a[2:0], except mem[0x0010] = 3'b010.
    logic [2:0]  vram [65536];
    bit          ram_init_done = 1'b0;
    int          wr_count  = 0;
    int          hi_writes = 0;
    int          viol      = 0;
    logic [15:0] last_waddr = '0;

    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 65536; i++) vram[i] <= 3'(i);
            vram[16'h0010] <= 3'b010;
            ram_init_done  <= 1'b1;
        end else begin
            ram_rdata <= vram[ram_addr];
            if (ram_we === 1'b1) begin
                vram[ram_addr] <= ram_wdata;
                wr_count       <= wr_count + 1;
                last_waddr     <= ram_addr;
                if (ram_addr > 16'd1023) hi_writes <= hi_writes + 1;
            end
        end
        if (ram_we === 1'b1 && vga_req === 1'b1) viol <= viol + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_color = '0;
        clr_req   = 1'b0;
        clr_color = '0;
        vga_req   = 1'b0;
        vga_addr  = '0;
    endtask

    typedef struct {
        logic        vga;
        logic [15:0] vaddr;
        logic        cwe;
        logic [15:0] caddr;
        logic [2:0]  ccol;
        logic        e_stall;
        logic        e_we;
        logic [15:0] e_addr;
        logic [2:0]  e_wdata;
        logic        e_chkaddr;
        logic        e_valid;
        logic [2:0]  e_vdata;
    } vec_t;

    function automatic vec_t mk(input logic vga, input logic [15:0] vaddr,
                                input logic cwe, input logic [15:0] caddr,
                                input logic [2:0] ccol, input logic e_stall,
                                input logic e_we, input logic [15:0] e_addr,
                                input logic [2:0] e_wdata, input logic e_valid,
                                input logic [2:0] e_vdata);
        vec_t v;
        v.vga = vga;         v.vaddr = vaddr;
        v.cwe = cwe;         v.caddr = caddr;       v.ccol = ccol;
        v.e_stall = e_stall; v.e_we = e_we;
        v.e_addr = e_addr;   v.e_wdata = e_wdata;
        v.e_chkaddr = vga || e_we;
        v.e_valid = e_valid; v.e_vdata = e_vdata;
        return v;
    endfunction

    vec_t tbl[$];

    int          busy_cycles;
    int          wc0;
    int          hi0;
    int          errs;
    int          lat_err;
    logic        exp_v1, exp_v2;
    logic [2:0]  exp_d1, exp_d2;
    logic        found;

    initial begin
        //            vga vaddr    cwe caddr    col stall we  ram_addr wd valid vdata
        tbl.push_back(mk(1, 16'h0010, 0, 16'h0000, 0, 0, 0, 16'h0010, 0, 0, 0)); // 0 read 0x10
        tbl.push_back(mk(1, 16'h0003, 0, 16'h0000, 0, 0, 0, 16'h0003, 0, 0, 0)); // 1 read 0x03
        tbl.push_back(mk(0, 16'h0000, 1, 16'h0005, 4, 0, 0, 16'h0000, 0, 1, 2)); // 2 push, data of 0x10
        tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0005, 4, 1, 3)); // 3 drain next cycle
        tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0)); // 4 FIFO empty
        tbl.push_back(mk(1, 16'h0020, 1, 16'h0100, 1, 0, 0, 16'h0020, 0, 0, 0)); // 5 reads block drain
        tbl.push_back(mk(1, 16'h0021, 1, 16'h0101, 2, 0, 0, 16'h0021, 0, 0, 0)); // 6
        tbl.push_back(mk(1, 16'h0022, 1, 16'h0102, 3, 0, 0, 16'h0022, 0, 1, 0)); // 7
        tbl.push_back(mk(1, 16'h0023, 1, 16'h0103, 5, 0, 0, 16'h0023, 0, 1, 1)); // 8
        tbl.push_back(mk(1, 16'h0024, 1, 16'h0104, 6, 1, 0, 16'h0024, 0, 1, 2)); // 9 full: 5th stalled
        tbl.push_back(mk(0, 16'h0000, 1, 16'h0104, 6, 1, 1, 16'h0100, 1, 1, 3)); // 10 pop while full, still stalled
        tbl.push_back(mk(0, 16'h0000, 1, 16'h0104, 6, 0, 1, 16'h0101, 2, 1, 4)); // 11 5th accepted
        tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0102, 3, 0, 0)); // 12
        tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0103, 5, 0, 0)); // 13
        tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0104, 6, 0, 0)); // 14
        tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0)); // 15 drained
        tbl.push_back(mk(1, 16'h0005, 0, 16'h0000, 0, 0, 0, 16'h0005, 0, 0, 0)); // 16 read back 0x05
        tbl.push_back(mk(1, 16'h0104, 0, 16'h0000, 0, 0, 0, 16'h0104, 0, 0, 0)); // 17 read back 0x104
        tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 4)); // 18
        tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 6)); // 19
        tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0)); // 20

        // ---------------- reset ----------------
        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(cpu_stall), 0);
        chk("rst_busy",  32'(clr_busy),  0);
        chk("rst_valid", 32'(vga_valid), 0);
        chk("rst_vdata", 32'(vga_data),  0);
        chk("rst_we",    32'(ram_we),    0);

        // ---------------- table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            vga_req   = tbl[i].vga;
            vga_addr  = tbl[i].vaddr;
            cpu_we    = tbl[i].cwe;
            cpu_addr  = tbl[i].caddr;
            cpu_color = tbl[i].ccol;
            #1;
            chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(tbl[i].e_stall));
            chk($sformatf("v%0d_we", i),    32'(ram_we),    32'(tbl[i].e_we));
            if (tbl[i].e_chkaddr)
                chk($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(tbl[i].e_addr));
            if (tbl[i].e_we)
                chk($sformatf("v%0d_wdata", i), 32'(ram_wdata), 32'(tbl[i].e_wdata));
            chk($sformatf("v%0d_valid", i), 32'(vga_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid)
                chk($sformatf("v%0d_vdata", i), 32'(vga_data), 32'(tbl[i].e_vdata));
        end

        // ---------------- clear discards buffered writes ----------------
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_idle();
            vga_req   = 1'b1;
            vga_addr  = 16'h3000;
            cpu_we    = 1'b1;
            cpu_addr  = 16'h2000 + 16'(i);
            cpu_color = 3'd7;
        end
        @(negedge clk);
        vga_req   = 1'b1;
        vga_addr  = 16'h3000;
        clr_req   = 1'b1;
        clr_color = 3'b001;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h2003;
        cpu_color = 3'd7;
        #1;
        chk("clr_acc_stall", 32'(cpu_stall), 1);
        chk("clr_acc_we",    32'(ram_we),    0);
        wc0 = wr_count;
        hi0 = hi_writes;

        @(negedge clk);
        drive_idle();
        cpu_we    = 1'b1;
        cpu_addr  = 16'h2004;
        cpu_color = 3'd7;
        #1;
        chk("clr_run_busy",  32'(clr_busy),  1);
        chk("clr_run_stall", 32'(cpu_stall), 1);
        chk("clr_first_addr", 32'(ram_addr), 0);
        busy_cycles = 1;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            drive_idle();
            #1;
            if (!clr_busy) break;
            busy_cycles++;
        end
        chk("clr_busy_cycles", 32'(busy_cycles), 1024);
        chk("clr_writes", 32'(wr_count - wc0), 1024);
        chk("clr_hi_writes", 32'(hi_writes - hi0), 0);
        chk("clr_last_addr", 32'(last_waddr), 1023);
        errs = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_idle();
            #1;
            if (ram_we !== 1'b0) errs++;
        end
        chk("clr_fifo_flushed", 32'(errs), 0);
        errs = 0;
        for (int a = 0; a < 1024; a++) if (vram[a] !== 3'b001) errs++;
        chk("clr_fill", 32'(errs), 0);
        chk("clr_no_2000", 32'(vram[16'h2000]), 0);
        chk("clr_1024_kept", 32'(vram[1024]), 0);

        // ---------------- clear with VGA read every other cycle ----------------
        @(negedge clk);
        drive_idle();
        clr_req   = 1'b1;
        clr_color = 3'b110;
        #1;
        chk("clr2_acc_stall", 32'(cpu_stall), 1);
        exp_v1 = 1'b0; exp_d1 = '0;
        exp_v2 = 1'b0; exp_d2 = '0;
        lat_err = 0;
        busy_cycles = 0;
        wc0 = wr_count;
        hi0 = hi_writes;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            drive_idle();
            vga_req  = (k % 2 == 0);
            vga_addr = 16'h3000 + 16'(k);
            clr_req  = (k < 100);       // ignored while clearing
            clr_color = 3'b011;
            #1;
            if (vga_valid !== exp_v2 || (exp_v2 && vga_data !== exp_d2)) lat_err++;
            exp_v2 = exp_v1;  exp_d2 = exp_d1;
            exp_v1 = vga_req; exp_d1 = 3'(k);
            if (!clr_busy) break;
            busy_cycles++;
        end
        chk("clr2_busy_cycles", 32'(busy_cycles), 2048);
        chk("clr2_read_latency_errs", 32'(lat_err), 0);
        chk("clr2_writes", 32'(wr_count - wc0), 1024);
        chk("clr2_hi_writes", 32'(hi_writes - hi0), 0);
        chk("clr2_last_addr", 32'(last_waddr), 1023);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        errs = 0;
        for (int a = 0; a < 1024; a++) if (vram[a] !== 3'b110) errs++;
        chk("clr2_fill", 32'(errs), 0);

        // ---------------- reset mid-clear ----------------
        @(negedge clk);
        drive_idle();
        clr_req   = 1'b1;
        clr_color = 3'b101;
        found = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            drive_idle();
            #1;
            if (ram_we === 1'b1 && ram_addr === 16'h0200) begin
                found = 1'b1;
                rst   = 1'b1;
                break;
            end
        end
        chk("rst_mid_reached_0200", 32'(found), 1);
        @(negedge clk);
        #1;
        chk("rst_mid_busy",  32'(clr_busy),  0);
        chk("rst_mid_we",    32'(ram_we),    0);
        chk("rst_mid_stall", 32'(cpu_stall), 0);
        chk("rst_mid_valid", 32'(vga_valid), 0);
        rst = 1'b0;
        @(negedge clk);
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0040;
        cpu_color = 3'b010;
        #1;
        chk("post_rst_stall", 32'(cpu_stall), 0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("post_rst_we",   32'(ram_we),   1);
        chk("post_rst_addr", 32'(ram_addr), 16'h0040);

        // RAM write must never coincide with a VGA read anywhere in the run.
        @(negedge clk);
        chk("we_during_vga", 32'(viol), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit in case the stimulus itself stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
